// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
// Shares one RAM (separate read/write address pins, 1-cycle registered read)
// between a priority CPU port (0) and a loader/debug port (1). Port 1 is
// guaranteed a grant after MAX_WAIT consecutive denied cycles.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req/we/addr/wdata{0,1}    requester inputs, held until granted
//   gnt{0,1}                  access issued this cycle (combinational)
//   rvalid{0,1}, rdata{0,1}   read data, one cycle after a read grant
//   err1                      port-1 write was dropped (protect feature)
//   mem_*                     RAM pins
//
// Optional feature macro: DATA_RAM_ARB_WPROT_EN
//   Port-1 writes below PROT_LIMIT are granted but not committed; err1
//   pulses in the following cycle. Without the macro err1 is tied 0.

module data_ram_arbiter #(
    parameter int DW         = 8,
    parameter int AW         = 8,
    parameter int MAX_WAIT   = 4,
    parameter int PROT_LIMIT = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          err1,
    output logic [AW-1:0] mem_read_addr,
    output logic [AW-1:0] mem_write_addr,
    output logic          mem_write,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int              WCW        = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]  MAX_WAIT_C = WCW'(MAX_WAIT);

    logic [WCW-1:0] r_wait_cnt;
    logic           r_rvalid0;
    logic           r_rvalid1;
    logic           w_starved;
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_we1_eff;

    // Port 1 overrides port 0 only once it has waited MAX_WAIT cycles.
    assign w_starved = req1 && (r_wait_cnt == MAX_WAIT_C);
    assign w_gnt1    = !rst && req1 && (w_starved || !req0);
    assign w_gnt0    = !rst && req0 && !w_starved;

`ifdef DATA_RAM_ARB_WPROT_EN
    localparam logic [AW:0] PROT_C = (AW + 1)'(PROT_LIMIT);

    logic w_p1_blocked;
    logic r_err1;

    assign w_p1_blocked = w_gnt1 && we1 && ({1'b0, addr1} < PROT_C);
    assign w_we1_eff    = we1 && !w_p1_blocked;

    always_ff @(posedge clk) begin
        if (rst) r_err1 <= 1'b0;
        else     r_err1 <= w_p1_blocked;
    end

    assign err1 = r_err1;
`else
    assign w_we1_eff = we1;
    assign err1      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || w_gnt1 || !req1) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != MAX_WAIT_C) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Reads granted in the cycle before rst still report; grants are
    // suppressed during rst so rvalid drops from the second rst cycle.
    always_ff @(posedge clk) begin
        r_rvalid0 <= w_gnt0 && !we0;
        r_rvalid1 <= w_gnt1 && !we1;
    end

    always_comb begin
        mem_read_addr  = '0;
        mem_write_addr = '0;
        mem_write      = 1'b0;
        mem_din        = '0;
        if (w_gnt0) begin
            mem_read_addr  = addr0;
            mem_write_addr = addr0;
            mem_write      = we0;
            mem_din        = wdata0;
        end else if (w_gnt1) begin
            mem_read_addr  = addr1;
            mem_write_addr = addr1;
            mem_write      = w_we1_eff;
            mem_din        = wdata1;
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = mem_dout;
    assign rdata1  = mem_dout;

endmodule

// File: tb/tb_data_ram_arbiter.sv
module tb_data_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, rvalid0, gnt1, rvalid1, err1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] mem_read_addr, mem_write_addr, mem_din, mem_dout;
    logic       mem_write;

    logic [7:0] ram [0:255];
    logic       pl_en;
    logic [7:0] pl_addr, pl_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .err1(err1),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_write(mem_write), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // RAM model: read-before-write, registered read, plus a preload path.
    always @(posedge clk) begin
        if (pl_en)          ram[pl_addr] <= pl_data;
        else if (mem_write) ram[mem_write_addr] <= mem_din;
        mem_dout <= ram[mem_read_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'd1; wdata0 = 8'h00;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'd2; wdata1 = 8'h00;
        #1;

        // Reset held 3 cycles with both ports requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_gnt0", gnt0, 1'b0);
            check("rst_gnt1", gnt1, 1'b0);
            check("rst_mem_write", mem_write, 1'b0);
            check("rst_mem_addr", mem_read_addr, 8'd0);
            if (i > 0) begin
                check("rst_rvalid0", rvalid0, 1'b0);
                check("rst_rvalid1", rvalid1, 1'b0);
                check("rst_err1", err1, 1'b0);
            end
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_gnt0", gnt0, 1'b1);
        check("post_rst_gnt1", gnt1, 1'b0);
        step();
        idle();

        preload(8'd140, 8'h6D);
        preload(8'd10, 8'hA0);
        preload(8'd11, 8'hA1);
        preload(8'd12, 8'hA2);
        preload(8'd5, 8'h33);
        step();

        // Single read, port 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'd140;
        @(negedge clk);
        check("rd0_gnt0", gnt0, 1'b1);
        check("rd0_addr", mem_read_addr, 8'd140);
        check("rd0_mem_write", mem_write, 1'b0);
        step(); idle();
        @(negedge clk);
        check("rd0_rvalid0", rvalid0, 1'b1);
        check("rd0_rdata0", rdata0, 8'h6D);
        check("rd0_rvalid1", rvalid1, 1'b0);
        step();
        @(negedge clk);
        check("rd0_rvalid0_drop", rvalid0, 1'b0);

        // Single read, port 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'd140;
        @(negedge clk);
        check("rd1_gnt1", gnt1, 1'b1);
        check("rd1_gnt0", gnt0, 1'b0);
        step(); idle();
        @(negedge clk);
        check("rd1_rvalid1", rvalid1, 1'b1);
        check("rd1_rdata1", rdata1, 8'h6D);
        check("rd1_rvalid0", rvalid0, 1'b0);
        step();

        // Write then read, port 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'd135; wdata0 = 8'h02;
        @(negedge clk);
        check("wr0_gnt0", gnt0, 1'b1);
        check("wr0_mem_write", mem_write, 1'b1);
        check("wr0_waddr", mem_write_addr, 8'd135);
        check("wr0_din", mem_din, 8'h02);
        step();
        we0 = 1'b0;
        @(negedge clk);
        check("wr0_no_rvalid", rvalid0, 1'b0);
        check("rdback_gnt0", gnt0, 1'b1);
        step(); idle();
        @(negedge clk);
        check("rdback_rvalid0", rvalid0, 1'b1);
        check("rdback_rdata0", rdata0, 8'h02);
        step();

        // Starvation bound: 4x gnt0 then 1x gnt1, three times
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'd20;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'd21;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("starve_gnt0_%0d", i), gnt0, (i % 5) != 4);
            check($sformatf("starve_gnt1_%0d", i), gnt1, (i % 5) == 4);
            if (i % 5 == 0)
                check($sformatf("starve_wcnt_%0d", i), 32'(dut.r_wait_cnt), 32'd0);
            step();
        end
        idle();
        @(negedge clk);
        check("starve_wcnt_end", 32'(dut.r_wait_cnt), 32'd0);
        step();

        // Port 1 alone, back-to-back reads
        req1 = 1'b1; we1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addr1 = 8'(10 + k);
            @(negedge clk);
            check($sformatf("p1_gnt1_%0d", k), gnt1, 1'b1);
            check($sformatf("p1_gnt0_%0d", k), gnt0, 1'b0);
            check($sformatf("p1_rvalid1_%0d", k), rvalid1, k > 0);
            if (k > 0)
                check($sformatf("p1_rdata1_%0d", k), rdata1, 32'hA0 + 32'(k - 1));
            step();
        end
        idle();
        @(negedge clk);
        check("p1_rvalid1_last", rvalid1, 1'b1);
        check("p1_rdata1_last", rdata1, 8'hA2);
        step();
        @(negedge clk);
        check("p1_rvalid1_done", rvalid1, 1'b0);

        // Reset mid-operation
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'd140;
        @(negedge clk);
        check("midrst_gnt0", gnt0, 1'b1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_nogrant", gnt0, 1'b0);
        check("midrst_rvalid0_1st", rvalid0, 1'b1);
        step();
        @(negedge clk);
        check("midrst_rvalid0_2nd", rvalid0, 1'b0);
        step();
        rst = 1'b0; idle();
        step();

`ifdef DATA_RAM_ARB_WPROT_EN
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'd5; wdata1 = 8'hFF;
        @(negedge clk);
        check("wp_low_gnt1", gnt1, 1'b1);
        check("wp_low_mem_write", mem_write, 1'b0);
        step(); idle();
        @(negedge clk);
        check("wp_low_err1", err1, 1'b1);
        check("wp_low_ram", ram[5], 8'h33);
        check("wp_low_no_rvalid", rvalid1, 1'b0);
        step();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'd200; wdata1 = 8'hFF;
        @(negedge clk);
        check("wp_high_gnt1", gnt1, 1'b1);
        check("wp_high_mem_write", mem_write, 1'b1);
        step(); idle();
        @(negedge clk);
        check("wp_high_err1", err1, 1'b0);
        check("wp_high_ram", ram[200], 8'hFF);
        step();
`else
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'd5; wdata1 = 8'hFF;
        @(negedge clk);
        check("wr1_gnt1", gnt1, 1'b1);
        check("wr1_mem_write", mem_write, 1'b1);
        check("wr1_din", mem_din, 8'hFF);
        step(); idle();
        @(negedge clk);
        check("wr1_err1", err1, 1'b0);
        check("wr1_ram", ram[5], 8'hFF);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-ported-per-direction 8x256 data RAM between two requesters.
- Port 0 is the CPU data port and has priority. Port 1 is the secondary loader/debug port.
- Port 1 is protected from starvation by a bounded-wait counter.
- Sits between the requesters and the RAM's read_addr/write_addr/write/din/dout pins. It compensates for the RAM's 1-cycle registered read.

Parameters:
- DW, 8, data width.
- AW, 8, address width.
- MAX_WAIT, 4, max consecutive cycles port 1 may be denied while requesting (legal range 1..255).
- PROT_LIMIT, 128, port-1 write-protect boundary (used only with the optional feature).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  synchronous active-high reset.
- req0  input  1  port 0 request; held with we0/addr0/wdata0 stable until gnt0.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  AW  port 0 address.
- wdata0  input  DW  port 0 write data.
- gnt0  output  1  port 0 access issued this cycle.
- rvalid0  output  1  port 0 read data valid.
- rdata0  output  DW  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1.
- err1  output  1  port 1 write dropped (optional feature).
- mem_read_addr  output  AW  to RAM read_addr.
- mem_write_addr  output  AW  to RAM write_addr.
- mem_write  output  1  to RAM write.
- mem_din  output  DW  to RAM din.
- mem_dout  input  DW  from RAM dout (valid 1 cycle after address).

Behaviour:
- Access rule: at most one access per cycle. Grant is combinational, same cycle as the request.
- Arbitration:
  - If rst=1: no grant.
  - Else if req1 && wait_cnt==MAX_WAIT: gnt1.
  - Else if req0: gnt0.
  - Else if req1: gnt1.
  - Else: idle.
- wait_cnt: registered, width clog2(MAX_WAIT+1).
  - Clears to 0 on rst, on gnt1, or when req1=0.
  - Increments when req1 && !gnt1; saturates at MAX_WAIT.
- Granted port k drives:
  - mem_read_addr = mem_write_addr = addrk.
  - mem_write = wek.
  - mem_din = wdatak.
- Idle: addresses 0, mem_write 0, mem_din 0.
- Read latency: rvalidk <= gntk && !wek, registered, so it asserts exactly 1 cycle after the grant. rdata0 = rdata1 = mem_dout, meaningful only when the corresponding rvalid=1.
- Writes: committed by the RAM at the grant-cycle posedge. No rvalid is produced for a write.
- Back-to-back: a grant every cycle is legal. A read followed by a write to the same address returns pre-write data (RAM semantics); the arbiter adds no forwarding.
- A requester that drops req without a grant loses nothing; no state is kept except wait_cnt clearing.
- Reset values: gnt0=gnt1=0, rvalid0=rvalid1=0, err1=0, mem_write=0, addresses 0, wait_cnt=0.
- Reset mid-operation: a read granted in the cycle before rst rises still shows rvalid during the first rst cycle, because rvalid is registered from the prior grant. All rvalid are 0 from the second rst cycle onward. No grants are issued while rst=1.

Optional Feature:
- Macro: DATA_RAM_ARB_WPROT_EN.
- Defined: a port-1 write with addr1 < PROT_LIMIT is still granted (gnt1=1, wait_cnt clears), but mem_write is forced 0. err1 pulses 1 in the following cycle (registered).
- Port-1 reads and all port-0 accesses are unaffected.
- Not defined: err1 is tied 0 and all port-1 writes pass through.

Test Plan:
- Reset: hold rst 3 cycles with req0=req1=1 -> gnt0=gnt1=0, mem_write=0, rvalid=0 throughout. First grant (gnt0) occurs in the first cycle after rst falls.
- Single read:
  - Preload ram[140]=0x6D; req0=1, we0=0, addr0=140 for 1 cycle -> gnt0 same cycle, rvalid0=1 and rdata0=0x6D next cycle.
  - Repeat on port 1 -> same result on rvalid1/rdata1.
- Write then read: port0 writes 0x02 to 135, next cycle reads 135 -> rvalid0 in the following cycle with rdata0=0x02.
- Starvation bound (MAX_WAIT=4): req0=req1=1 continuously for 15 cycles -> grant pattern is gnt0 for 4 cycles then gnt1 for 1 cycle, repeated 3 times; wait_cnt returns to 0 after each gnt1.
- Port 1 alone: req0=0, req1 reads addrs 10,11,12 back-to-back -> gnt1 in 3 consecutive cycles; rvalid1 high for 3 cycles, each offset by 1 cycle.
- WPROT (macro defined, PROT_LIMIT=128):
  - Port1 writes 0xFF to addr 5 -> gnt1=1, mem_write=0, err1=1 next cycle, ram[5] unchanged.
  - Port1 writes 0xFF to addr 200 -> ram[200]=0xFF, err1=0.
